// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: RV64 major opcodes and the
// result class each opcode selects for the register-file write.
package wb_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP_W     = 7'b0111011;
    localparam logic [6:0] OP_OP_IMM_W = 7'b0011011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_FENCE    = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_ALU,
        WB_ALU_W,
        WB_LOAD,
        WB_LINK
    } wb_class_e;

    // Map an opcode to the source of its write-back value.
    function automatic wb_class_e classify(input logic [6:0] opcode);
        case (opcode)
            OP_OP, OP_OP_IMM, OP_AUIPC, OP_LUI:         return WB_ALU;
            OP_OP_W, OP_OP_IMM_W:                       return WB_ALU_W;
            OP_LOAD:                                    return WB_LOAD;
            OP_JAL, OP_JALR:                            return WB_LINK;
            OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM:   return WB_NONE;
            default:                                    return WB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_result_sel.sv
// Per-opcode result selection for the granted completion: picks ALU, word-op
// sign-extended ALU, load data or the pc+4 link value, and decides whether
// the register file is written at all (x0 writes are dropped).
module wb_result_sel
    import wb_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int REG_IDX_W = 5
) (
    input  logic [6:0]           opcode,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [XLEN-1:0]      alu,
    input  logic [XLEN-1:0]      load,
    input  logic [XLEN-1:0]      pc,
    output logic                 we,
    output logic [XLEN-1:0]      data
);

    wb_class_e cls;

    // Classify the opcode and build the write value and enable.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        data = '0;
        cls  = classify(opcode);
        case (cls)
            WB_ALU:   data = alu;
            WB_ALU_W: data = {{(XLEN-32){alu[31]}}, alu[31:0]};
            WB_LOAD:  data = load;
            WB_LINK:  data = pc + XLEN'(4);
            default:  data = '0;
        endcase
        we = (cls != WB_NONE) && (rd != '0);
    end

endmodule

// File: rtl/wb_arbiter.sv
// Multi-source write-back stage: round-robin arbitration of NUM_SRC completion
// sources onto the single register-file write port, registered write/retire
// outputs, and an optional retired-instruction counter enabled by the
// WB_RETIRE_CNT_EN macro.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int XLEN      = 64,
    parameter  int NUM_SRC   = 2,
    parameter  int REG_IDX_W = 5,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*7-1:0]           src_opcode,
    input  logic [NUM_SRC*REG_IDX_W-1:0]   src_rd,
    input  logic [NUM_SRC*XLEN-1:0]        src_alu,
    input  logic [NUM_SRC*XLEN-1:0]        src_load,
    input  logic [NUM_SRC*XLEN-1:0]        src_pc,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]                    retired_count,
`endif
    output logic                           rf_we,
    output logic [REG_IDX_W-1:0]           rf_waddr,
    output logic [XLEN-1:0]                rf_wdata,
    output logic                           retire_valid,
    output logic [SRC_W-1:0]               retire_src
);

    logic [SRC_W-1:0]     rr_ptr;
    logic                 gnt_valid;
    logic [SRC_W-1:0]     gnt_idx;
    logic [SRC_W-1:0]     next_ptr;
    int                   scan_idx;

    logic [6:0]           gnt_opcode;
    logic [REG_IDX_W-1:0] gnt_rd;
    logic [XLEN-1:0]      gnt_alu;
    logic [XLEN-1:0]      gnt_load;
    logic [XLEN-1:0]      gnt_pc;
    logic                 sel_we;
    logic [XLEN-1:0]      sel_data;

    // Grant the first valid source at or after rr_ptr, wrapping; nothing during reset.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        src_ready = '0;
        if (!reset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                scan_idx = (int'(rr_ptr) + k) % NUM_SRC;
                if (!gnt_valid && src_valid[scan_idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SRC_W'(scan_idx);
                end
            end
        end
        if (gnt_valid) begin
            src_ready[gnt_idx] = 1'b1;
        end
    end

    // Pointer moves to the source just after the winner so contention rotates.
    assign next_ptr = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

    // Route the granted source's payload into the single result selector.
    assign gnt_opcode = src_opcode[int'(gnt_idx)*7 +: 7];
    assign gnt_rd     = src_rd[int'(gnt_idx)*REG_IDX_W +: REG_IDX_W];
    assign gnt_alu    = src_alu[int'(gnt_idx)*XLEN +: XLEN];
    assign gnt_load   = src_load[int'(gnt_idx)*XLEN +: XLEN];
    assign gnt_pc     = src_pc[int'(gnt_idx)*XLEN +: XLEN];

    wb_result_sel #(
        .XLEN      (XLEN),
        .REG_IDX_W (REG_IDX_W)
    ) u_result_sel (
        .opcode (gnt_opcode),
        .rd     (gnt_rd),
        .alu    (gnt_alu),
        .load   (gnt_load),
        .pc     (gnt_pc),
        .we     (sel_we),
        .data   (sel_data)
    );

    // Output register and arbitration pointer; address/data hold when idle.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-high, so it is tested inside the clocked branch, not in the sensitivity list.
        if (reset) begin
            rr_ptr       <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            retire_valid <= 1'b0;
            retire_src   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rf_we        <= gnt_valid & sel_we;
            retire_valid <= gnt_valid;
            if (gnt_valid) begin
                rr_ptr     <= next_ptr;
                rf_waddr   <= gnt_rd;
                rf_wdata   <= sel_data;
                retire_src <= gnt_idx;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Count every cycle with a registered retirement; wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (retire_valid) begin
            retired_count <= retired_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (NUM_SRC=2, XLEN=64).
// Inputs change on the falling edge; registered outputs are sampled on the
// falling edge after the rising edge that loads them.
module tb_wb_arbiter;

    localparam int XLEN      = 64;
    localparam int NUM_SRC   = 2;
    localparam int REG_IDX_W = 5;

    logic                         clk;
    logic                         reset;
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC-1:0]           src_ready;
    logic [NUM_SRC*7-1:0]         src_opcode;
    logic [NUM_SRC*REG_IDX_W-1:0] src_rd;
    logic [NUM_SRC*XLEN-1:0]      src_alu;
    logic [NUM_SRC*XLEN-1:0]      src_load;
    logic [NUM_SRC*XLEN-1:0]      src_pc;
    logic                         rf_we;
    logic [REG_IDX_W-1:0]         rf_waddr;
    logic [XLEN-1:0]              rf_wdata;
    logic                         retire_valid;
    logic [0:0]                   retire_src;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]                  retired_count;
`endif

    int n_pass;
    int n_total;

    wb_arbiter #(
        .XLEN      (XLEN),
        .NUM_SRC   (NUM_SRC),
        .REG_IDX_W (REG_IDX_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_opcode    (src_opcode),
        .src_rd        (src_rd),
        .src_alu       (src_alu),
        .src_load      (src_load),
        .src_pc        (src_pc),
`ifdef WB_RETIRE_CNT_EN
        .retired_count (retired_count),
`endif
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .retire_valid  (retire_valid),
        .retire_src    (retire_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic v, input logic [6:0] op,
                           input logic [4:0] rd, input logic [63:0] alu,
                           input logic [63:0] ld, input logic [63:0] pc);
        src_valid[i]                        = v;
        src_opcode[i*7 +: 7]                = op;
        src_rd[i*REG_IDX_W +: REG_IDX_W]    = rd;
        src_alu[i*XLEN +: XLEN]             = alu;
        src_load[i*XLEN +: XLEN]            = ld;
        src_pc[i*XLEN +: XLEN]              = pc;
    endtask

    // Issue one instruction on source 0 and leave the bench one cycle later,
    // when the registered result is visible.
    task automatic single_op(input logic [6:0] op, input logic [4:0] rd,
                             input logic [63:0] alu, input logic [63:0] ld,
                             input logic [63:0] pc);
        set_src(0, 1'b1, op, rd, alu, ld, pc);
        step();
        src_valid[0] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_src(0, 1'b1, 7'b0110011, 5'd3, 64'h33, 64'h0, 64'h0);
        set_src(1, 1'b1, 7'b0110011, 5'd4, 64'h44, 64'h0, 64'h0);
        step();
        step();
        n_total++; if (src_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", src_ready); else n_pass++;
        n_total++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", rf_we); else n_pass++;
        n_total++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr: got %0d expected 0", rf_waddr); else n_pass++;
        n_total++; if (rf_wdata !== 64'h0) $display("FAIL reset_wdata: got %h expected 0", rf_wdata); else n_pass++;
        n_total++; if (retire_valid !== 1'b0) $display("FAIL reset_retire_valid: got %b expected 0", retire_valid); else n_pass++;
        n_total++; if (retire_src !== 1'b0) $display("FAIL reset_retire_src: got %b expected 0", retire_src); else n_pass++;
`ifdef WB_RETIRE_CNT_EN
        n_total++; if (retired_count !== 64'd0) $display("FAIL reset_count: got %0d expected 0", retired_count); else n_pass++;
`endif
        reset = 1'b0;
        #1;
        n_total++; if (src_ready !== 2'b01) $display("FAIL reset_first_grant: got %b expected 01", src_ready); else n_pass++;
        step();
        src_valid = '0;
        n_total++; if (retire_src !== 1'b0) $display("FAIL reset_first_src: got %b expected 0", retire_src); else n_pass++;
        n_total++; if (rf_wdata !== 64'h33) $display("FAIL reset_first_wdata: got %h expected 33", rf_wdata); else n_pass++;
        step();
    endtask

    task automatic test_alu();
        set_src(0, 1'b1, 7'b0110011, 5'd5, 64'h1234, 64'h0, 64'h0);
        #1;
        n_total++; if (src_ready !== 2'b01) $display("FAIL alu_ready: got %b expected 01", src_ready); else n_pass++;
        step();
        src_valid[0] = 1'b0;
        n_total++; if (rf_we !== 1'b1) $display("FAIL alu_we: got %b expected 1", rf_we); else n_pass++;
        n_total++; if (rf_waddr !== 5'd5) $display("FAIL alu_waddr: got %0d expected 5", rf_waddr); else n_pass++;
        n_total++; if (rf_wdata !== 64'h1234) $display("FAIL alu_wdata: got %h expected 1234", rf_wdata); else n_pass++;
        n_total++; if (retire_valid !== 1'b1) $display("FAIL alu_retire_valid: got %b expected 1", retire_valid); else n_pass++;
        n_total++; if (retire_src !== 1'b0) $display("FAIL alu_retire_src: got %b expected 0", retire_src); else n_pass++;
        step();
        n_total++; if (rf_we !== 1'b0) $display("FAIL idle_we: got %b expected 0", rf_we); else n_pass++;
        n_total++; if (retire_valid !== 1'b0) $display("FAIL idle_retire_valid: got %b expected 0", retire_valid); else n_pass++;
        n_total++; if (rf_waddr !== 5'd5) $display("FAIL idle_waddr_hold: got %0d expected 5", rf_waddr); else n_pass++;
        n_total++; if (rf_wdata !== 64'h1234) $display("FAIL idle_wdata_hold: got %h expected 1234", rf_wdata); else n_pass++;
    endtask

    task automatic test_word_op();
        single_op(7'b0011011, 5'd7, 64'h0000_0000_8000_0000, 64'h0, 64'h0);
        n_total++; if (rf_wdata !== 64'hFFFF_FFFF_8000_0000) $display("FAIL addiw_sext: got %h expected ffffffff80000000", rf_wdata); else n_pass++;
        n_total++; if (rf_we !== 1'b1) $display("FAIL addiw_we: got %b expected 1", rf_we); else n_pass++;
        single_op(7'b0111011, 5'd8, 64'hDEAD_BEEF_7FFF_FFFF, 64'h0, 64'h0);
        n_total++; if (rf_wdata !== 64'h0000_0000_7FFF_FFFF) $display("FAIL addw_zext_upper: got %h expected 000000007fffffff", rf_wdata); else n_pass++;
    endtask

    task automatic test_link();
        single_op(7'b1101111, 5'd1, 64'h55, 64'h66, 64'h1000);
        n_total++; if (rf_wdata !== 64'h1004) $display("FAIL jal_link: got %h expected 1004", rf_wdata); else n_pass++;
        n_total++; if (rf_waddr !== 5'd1) $display("FAIL jal_waddr: got %0d expected 1", rf_waddr); else n_pass++;
        single_op(7'b1100111, 5'd2, 64'h55, 64'h66, 64'hFFFF_FFFF_FFFF_FFFC);
        n_total++; if (rf_wdata !== 64'h0) $display("FAIL jalr_wrap: got %h expected 0", rf_wdata); else n_pass++;
        n_total++; if (rf_we !== 1'b1) $display("FAIL jalr_we: got %b expected 1", rf_we); else n_pass++;
    endtask

    task automatic test_no_write();
        single_op(7'b1101111, 5'd0, 64'h0, 64'h0, 64'h2000);
        n_total++; if (rf_we !== 1'b0) $display("FAIL jal_x0_we: got %b expected 0", rf_we); else n_pass++;
        n_total++; if (retire_valid !== 1'b1) $display("FAIL jal_x0_retire: got %b expected 1", retire_valid); else n_pass++;
        single_op(7'b0100011, 5'd3, 64'h77, 64'h0, 64'h0);
        n_total++; if (rf_we !== 1'b0) $display("FAIL store_we: got %b expected 0", rf_we); else n_pass++;
        n_total++; if (retire_valid !== 1'b1) $display("FAIL store_retire: got %b expected 1", retire_valid); else n_pass++;
        single_op(7'b0000000, 5'd4, 64'h77, 64'h0, 64'h0);
        n_total++; if (rf_we !== 1'b0) $display("FAIL unknown_op_we: got %b expected 0", rf_we); else n_pass++;
    endtask

    task automatic test_load();
        single_op(7'b0000011, 5'd9, 64'h1111, 64'hCAFE_BABE_1234_5678, 64'h0);
        n_total++; if (rf_wdata !== 64'hCAFE_BABE_1234_5678) $display("FAIL load_wdata: got %h expected cafebabe12345678", rf_wdata); else n_pass++;
        n_total++; if (rf_we !== 1'b1) $display("FAIL load_we: got %b expected 1", rf_we); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ready [4];
        logic       exp_src   [4];
        exp_ready[0] = 2'b01; exp_ready[1] = 2'b10; exp_ready[2] = 2'b01; exp_ready[3] = 2'b10;
        exp_src[0]   = 1'b0;  exp_src[1]   = 1'b1;  exp_src[2]   = 1'b0;  exp_src[3]   = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_src(0, 1'b1, 7'b0110011, 5'd10, 64'hA0, 64'h0, 64'h0);
        set_src(1, 1'b1, 7'b0110011, 5'd11, 64'hB1, 64'h0, 64'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++; if (src_ready !== exp_ready[c]) $display("FAIL rr_ready[%0d]: got %b expected %b", c, src_ready, exp_ready[c]); else n_pass++;
            step();
            n_total++; if (retire_src !== exp_src[c]) $display("FAIL rr_src[%0d]: got %b expected %b", c, retire_src, exp_src[c]); else n_pass++;
            n_total++; if (rf_waddr !== (exp_src[c] ? 5'd11 : 5'd10)) $display("FAIL rr_waddr[%0d]: got %0d expected %0d", c, rf_waddr, exp_src[c] ? 11 : 10); else n_pass++;
        end
        src_valid = '0;
        step();
        n_total++; if (retire_valid !== 1'b0) $display("FAIL rr_drain: got %b expected 0", retire_valid); else n_pass++;
`ifdef WB_RETIRE_CNT_EN
        n_total++; if (retired_count !== 64'd4) $display("FAIL rr_count: got %0d expected 4", retired_count); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        set_src(0, 1'b1, 7'b0110011, 5'd12, 64'hC0, 64'h0, 64'h0);
        set_src(1, 1'b1, 7'b0110011, 5'd13, 64'hD1, 64'h0, 64'h0);
        step();
        reset = 1'b1;
        #1;
        n_total++; if (src_ready !== 2'b00) $display("FAIL mid_reset_ready: got %b expected 00", src_ready); else n_pass++;
        step();
        n_total++; if (rf_we !== 1'b0) $display("FAIL mid_reset_we: got %b expected 0", rf_we); else n_pass++;
        n_total++; if (retire_valid !== 1'b0) $display("FAIL mid_reset_retire: got %b expected 0", retire_valid); else n_pass++;
        n_total++; if (rf_waddr !== 5'd0) $display("FAIL mid_reset_waddr: got %0d expected 0", rf_waddr); else n_pass++;
        n_total++; if (rf_wdata !== 64'h0) $display("FAIL mid_reset_wdata: got %h expected 0", rf_wdata); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (src_ready !== 2'b01) $display("FAIL mid_reset_first_grant: got %b expected 01", src_ready); else n_pass++;
        step();
        src_valid = '0;
        n_total++; if (retire_src !== 1'b0) $display("FAIL mid_reset_first_src: got %b expected 0", retire_src); else n_pass++;
        step();
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset      = 1'b1;
        src_valid  = '0;
        src_opcode = '0;
        src_rd     = '0;
        src_alu    = '0;
        src_load   = '0;
        src_pc     = '0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_word_op();
        test_link();
        test_no_write();
        test_load();
        test_round_robin();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
